// File: rtl/intr_coalescer_if.sv
// Interrupt coalescer signal bundle: completion/timer inputs, configuration and the host interrupt handshake.
interface intr_coalescer_if #(
  parameter int CNT_W = 16,
  parameter int AGE_W = 8
) ();
  logic             enable;
  logic             event_valid;
  logic             tick;
  logic [CNT_W-1:0] count_thresh;
  logic [AGE_W-1:0] tick_thresh;
  logic [AGE_W-1:0] holdoff_ticks;
  logic             irq;
  logic             irq_ack;
  logic [CNT_W-1:0] irq_cnt;
  logic [CNT_W-1:0] pending_cnt;

  modport master (
    output enable, event_valid, tick, count_thresh, tick_thresh, holdoff_ticks, irq_ack,
    input  irq, irq_cnt, pending_cnt
  );

  modport slave (
    input  enable, event_valid, tick, count_thresh, tick_thresh, holdoff_ticks, irq_ack,
    output irq, irq_cnt, pending_cnt
  );
endinterface

// File: rtl/intr_coalescer.sv
// Interrupt moderation: raises one level irq per batch of completions (count or age trigger),
// then enforces a tick-based holdoff after each acknowledge.
module intr_coalescer #(
  parameter int CNT_W = 16,
  parameter int AGE_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  intr_coalescer_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PEND = 2'd1;
  localparam logic [1:0] IRQ  = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [AGE_W-1:0] AGE_ONE = {{(AGE_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != {CNT_W{1'b1}}))
      return v + CNT_ONE;
    return v;
  endfunction

  function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] v, input logic inc);
    if (inc && (v != {AGE_W{1'b1}}))
      return v + AGE_ONE;
    return v;
  endfunction

  logic [1:0]       state, state_d;
  logic             irq, irq_d;
  logic [CNT_W-1:0] irq_cnt, irq_cnt_d;
  logic [CNT_W-1:0] pending_cnt, pending_d;
  logic [AGE_W-1:0] age, age_d;
  logic [AGE_W-1:0] hold_age, hold_age_d;

  logic [CNT_W-1:0] pend_inc;
  logic [AGE_W-1:0] age_inc;
  logic [AGE_W-1:0] hold_inc;
  logic [CNT_W-1:0] eff_thresh;
  logic             cnt_hit;
  logic             time_hit;

  // "Next" values: a same-cycle event and tick both count toward the fire decision
  assign pend_inc   = cnt_sat_inc(pending_cnt, bus.event_valid);
  assign age_inc    = age_sat_inc(age, bus.tick);
  assign hold_inc   = age_sat_inc(hold_age, bus.tick);
  assign eff_thresh = (bus.count_thresh == '0) ? CNT_ONE : bus.count_thresh;
  assign cnt_hit    = (pend_inc >= eff_thresh);
  assign time_hit   = (bus.tick_thresh != '0) && (age_inc >= bus.tick_thresh);

  always_comb begin
    state_d    = state;
    irq_d      = irq;
    irq_cnt_d  = irq_cnt;
    pending_d  = pending_cnt;
    age_d      = age;
    hold_age_d = hold_age;
    case (state)
      IDLE: begin
        // Ticks while idle do not start the age clock; only the first event does
        if (bus.event_valid) begin
          age_d = '0;
          if (bus.enable && cnt_hit) begin
            irq_d     = 1'b1;
            irq_cnt_d = pend_inc;
            pending_d = '0;
            state_d   = IRQ;
          end else begin
            pending_d = pend_inc;
            state_d   = PEND;
          end
        end
      end
      PEND: begin
        pending_d = pend_inc;
        age_d     = age_inc;
        if (bus.enable && (cnt_hit || time_hit)) begin
          irq_d     = 1'b1;
          irq_cnt_d = pend_inc;
          pending_d = '0;
          state_d   = IRQ;
        end
      end
      IRQ: begin
        pending_d = pend_inc;
        if (bus.irq_ack) begin
          irq_d = 1'b0;
          if (bus.holdoff_ticks == '0) begin
            age_d   = '0;
            state_d = (pend_inc != '0) ? PEND : IDLE;
          end else begin
            hold_age_d = '0;
            state_d    = HOLD;
          end
        end
      end
      HOLD: begin
        pending_d  = pend_inc;
        hold_age_d = hold_inc;
        if (hold_inc >= bus.holdoff_ticks) begin
          age_d   = '0;
          state_d = (pend_inc != '0) ? PEND : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      irq         <= 1'b0;
      irq_cnt     <= '0;
      pending_cnt <= '0;
      age         <= '0;
      hold_age    <= '0;
    end else begin
      state       <= state_d;
      irq         <= irq_d;
      irq_cnt     <= irq_cnt_d;
      pending_cnt <= pending_d;
      age         <= age_d;
      hold_age    <= hold_age_d;
    end
  end

  assign bus.irq         = irq;
  assign bus.irq_cnt     = irq_cnt;
  assign bus.pending_cnt = pending_cnt;

endmodule

// File: tb/tb_intr_coalescer.sv
// Directed bench for intr_coalescer: default-width instance plus a CNT_W=4 instance for saturation.
module tb_intr_coalescer;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  intr_coalescer_if #(.CNT_W(16), .AGE_W(8)) b ();
  intr_coalescer_if #(.CNT_W(4),  .AGE_W(8)) b4 ();

  intr_coalescer #(.CNT_W(16), .AGE_W(8)) dut (.clk(clk), .rst(rst), .bus(b));
  intr_coalescer #(.CNT_W(4),  .AGE_W(8)) dut4 (.clk(clk), .rst(rst), .bus(b4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    b.enable = 1'b0; b.event_valid = 1'b0; b.tick = 1'b0; b.irq_ack = 1'b0;
    b.count_thresh = 16'd0; b.tick_thresh = 8'd0; b.holdoff_ticks = 8'd0;
    b4.enable = 1'b0; b4.event_valid = 1'b0; b4.tick = 1'b0; b4.irq_ack = 1'b0;
    b4.count_thresh = 4'd0; b4.tick_thresh = 8'd0; b4.holdoff_ticks = 8'd0;
    step(2);
    rst = 1'b0;
    step(1);
    check("rst_irq", 32'(b.irq), 0);
    check("rst_irq_cnt", 32'(b.irq_cnt), 0);
    check("rst_pending", 32'(b.pending_cnt), 0);
    check("rst4_pending", 32'(b4.pending_cnt), 0);

    // Count trigger: 4 back-to-back events
    b.enable = 1'b1; b.count_thresh = 16'd4;
    b.event_valid = 1'b1;
    step(3);
    check("cnt_pend3", 32'(b.pending_cnt), 3);
    check("cnt_no_irq_yet", 32'(b.irq), 0);
    step(1);
    b.event_valid = 1'b0;
    check("cnt_irq", 32'(b.irq), 1);
    check("cnt_irq_cnt", 32'(b.irq_cnt), 4);
    check("cnt_pend_clr", 32'(b.pending_cnt), 0);
    step(5);
    check("cnt_irq_held", 32'(b.irq), 1);
    b.irq_ack = 1'b1;
    step(1);
    b.irq_ack = 1'b0;
    check("cnt_ack_irq", 32'(b.irq), 0);
    b.tick = 1'b1;
    step(1);
    b.tick = 1'b0;
    check("idle_tick_pend", 32'(b.pending_cnt), 0);
    b.irq_ack = 1'b1;
    step(1);
    b.irq_ack = 1'b0;
    check("spur_ack_irq", 32'(b.irq), 0);
    check("spur_ack_irq_cnt", 32'(b.irq_cnt), 4);
    check("spur_ack_pend", 32'(b.pending_cnt), 0);

    // Age trigger: one event, third tick fires
    b.count_thresh = 16'd100; b.tick_thresh = 8'd3;
    b.event_valid = 1'b1;
    step(1);
    b.event_valid = 1'b0;
    check("age_pend1", 32'(b.pending_cnt), 1);
    for (int t = 1; t <= 3; t++) begin
      step(4);
      b.tick = 1'b1;
      step(1);
      b.tick = 1'b0;
      check($sformatf("age_tick%0d_irq", t), 32'(b.irq), (t == 3) ? 1 : 0);
    end
    check("age_irq_cnt", 32'(b.irq_cnt), 1);
    b.irq_ack = 1'b1;
    step(1);
    b.irq_ack = 1'b0;
    check("age_ack_irq", 32'(b.irq), 0);

    // Holdoff: events during IRQ, then two ticks of holdoff
    b.count_thresh = 16'd4; b.tick_thresh = 8'd0; b.holdoff_ticks = 8'd2;
    b.event_valid = 1'b1;
    step(4);
    check("hold_irq", 32'(b.irq), 1);
    check("hold_irq_cnt", 32'(b.irq_cnt), 4);
    step(3);
    b.event_valid = 1'b0;
    check("hold_pend_in_irq", 32'(b.pending_cnt), 3);
    check("hold_irq_cnt_frozen", 32'(b.irq_cnt), 4);
    b.irq_ack = 1'b1;
    step(1);
    b.irq_ack = 1'b0;
    check("hold_ack_irq", 32'(b.irq), 0);
    step(3);
    check("hold_no_irq", 32'(b.irq), 0);
    b.tick = 1'b1;
    step(2);
    b.tick = 1'b0;
    step(1);
    check("hold_done_no_irq", 32'(b.irq), 0);
    check("hold_done_pend", 32'(b.pending_cnt), 3);
    b.event_valid = 1'b1;
    step(1);
    b.event_valid = 1'b0;
    check("hold_refire_irq", 32'(b.irq), 1);
    check("hold_refire_cnt", 32'(b.irq_cnt), 4);
    b.holdoff_ticks = 8'd0;
    b.irq_ack = 1'b1;
    step(1);
    b.irq_ack = 1'b0;

    // Same-cycle event and tick with count_thresh=2
    b.count_thresh = 16'd2; b.tick_thresh = 8'd5;
    b.event_valid = 1'b1;
    step(1);
    check("same_pend1", 32'(b.pending_cnt), 1);
    b.tick = 1'b1;
    step(1);
    b.event_valid = 1'b0; b.tick = 1'b0;
    check("same_irq", 32'(b.irq), 1);
    check("same_irq_cnt", 32'(b.irq_cnt), 2);
    b.irq_ack = 1'b1;
    step(1);
    b.irq_ack = 1'b0;

    // enable=0 accumulates without firing; re-enable fires next cycle
    b.enable = 1'b0; b.count_thresh = 16'd4;
    b.event_valid = 1'b1;
    step(10);
    b.event_valid = 1'b0;
    check("dis_irq", 32'(b.irq), 0);
    check("dis_pend", 32'(b.pending_cnt), 10);
    b.enable = 1'b1;
    step(1);
    check("en_irq", 32'(b.irq), 1);
    check("en_irq_cnt", 32'(b.irq_cnt), 10);
    check("en_pend_clr", 32'(b.pending_cnt), 0);
    b.irq_ack = 1'b1;
    step(1);
    b.irq_ack = 1'b0;

    // Narrow instance saturates pending_cnt at 15
    b4.event_valid = 1'b1;
    step(20);
    b4.event_valid = 1'b0;
    check("sat4_pend", 32'(b4.pending_cnt), 15);
    check("sat4_no_irq", 32'(b4.irq), 0);
    b4.enable = 1'b1;
    step(1);
    check("sat4_irq", 32'(b4.irq), 1);
    check("sat4_irq_cnt", 32'(b4.irq_cnt), 15);

    // count_thresh=1 fires straight from IDLE; then reset while irq is high
    b.count_thresh = 16'd1;
    b.event_valid = 1'b1;
    step(1);
    check("thr1_irq", 32'(b.irq), 1);
    check("thr1_irq_cnt", 32'(b.irq_cnt), 1);
    step(1);
    b.event_valid = 1'b0;
    check("thr1_pend_in_irq", 32'(b.pending_cnt), 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("mid_rst_irq", 32'(b.irq), 0);
    check("mid_rst_pend", 32'(b.pending_cnt), 0);
    check("mid_rst_irq_cnt", 32'(b.irq_cnt), 0);
    check("mid_rst4_irq", 32'(b4.irq), 0);
    check("mid_rst4_irq_cnt", 32'(b4.irq_cnt), 0);
    step(2);
    check("post_rst_irq", 32'(b.irq), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/intr_coalescer.md
Name: intr_coalescer

Overview:
- Interrupt moderation block for the NIC completion path.
- Counts completion events. Consumes the periodic single-cycle `tick` pulse produced by the interval timer.
- Raises one interrupt when either the event count reaches a threshold or enough ticks have elapsed since the first unserviced event.
- Enforces a tick-based holdoff gap after each acknowledged interrupt; sits between the completion logic and the host interrupt line.

Parameters:
CNT_W, 16, width of event counters and count threshold
AGE_W, 8, width of tick-age counters, tick threshold and holdoff

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
enable  input  1  1 = firing allowed; 0 = events still counted, no new irq
event_valid  input  1  one completion event per cycle when high
tick  input  1  single-cycle timeout pulse from interval timer
count_thresh  input  CNT_W  fire when pending events >= this (0 treated as 1)
tick_thresh  input  AGE_W  fire when ticks since first pending event >= this (0 = time trigger disabled)
holdoff_ticks  input  AGE_W  ticks to wait after ack before next irq (0 = none)
irq  output  1  level interrupt, high until acknowledged
irq_ack  input  1  host acknowledge, sampled only while irq=1
irq_cnt  output  CNT_W  events covered by current/last irq, stable while irq=1
pending_cnt  output  CNT_W  events accumulated, not yet reported

Behaviour:
- Reset: state=IDLE, irq=0, irq_cnt=0, pending_cnt=0, age=0, hold_age=0. Reset mid-operation drops any pending events and any asserted irq on the next edge.
- Counting and timing rules:
  - pending_cnt saturates at 2^CNT_W-1; age and hold_age saturate at 2^AGE_W-1.
  - Fire decisions use post-increment ("next") values: an event and a tick in the same cycle both count.
- States and transitions:
  - IDLE: pending_cnt=0. event_valid -> pending_cnt=1, age=0, go PEND. A tick has no effect.
  - PEND: event_valid -> pending_cnt+1; tick -> age+1.
  - Fire condition: enable=1 AND (pending_next >= max(count_thresh,1) OR (tick_thresh!=0 AND age_next >= tick_thresh)).
  - On fire: irq_cnt <= pending_next, pending_cnt <= 0, irq <= 1, go IRQ. Latency: a qualifying event/tick at cycle N gives irq=1 at cycle N+1.
  - A same-cycle event_valid in the fire cycle is included in irq_cnt.
  - With enable=0, PEND keeps accumulating; firing is evaluated each cycle once enable returns to 1.
  - IRQ: irq held high; irq_cnt frozen.
    - event_valid increments pending_cnt from 0. Ticks do not age pending events in this state.
    - irq_ack=1: irq <= 0.
      - holdoff_ticks=0: go PEND with age=0 if pending_cnt (including a same-cycle event) > 0, else IDLE.
      - holdoff_ticks!=0: go HOLD with hold_age=0.
  - HOLD: irq=0. Events accumulate; tick -> hold_age+1.
    - When hold_age_next >= holdoff_ticks: go PEND with age=0 if pending > 0, else IDLE. No firing occurs during HOLD.
- irq_ack while irq=0 is ignored. irq_ack in the same cycle as the fire cycle is ignored, since irq is not yet high.
- enable deassert while in IRQ or HOLD does not cancel the in-flight irq or the holdoff.
- Threshold changes take effect on the next cycle's evaluation.

Test Plan:
- count_thresh=4, tick_thresh=0: 4 events on consecutive cycles 10-13 -> irq=1 at cycle 14, irq_cnt=4, pending_cnt=0; ack at 20 -> irq=0 at 21, state IDLE.
- count_thresh=100, tick_thresh=3: 1 event, then ticks at +5, +10, +15 -> irq rises the cycle after the 3rd tick, irq_cnt=1.
- irq asserted with irq_cnt=4; 3 events while awaiting ack; holdoff_ticks=2; ack -> HOLD, no irq until 2 ticks. count_thresh=4 unmet (pending=3), so PEND with age=0; 1 more event -> irq with irq_cnt=4.
- Event and tick in the same cycle with count_thresh=2 and pending=1 -> fires next cycle with irq_cnt=2. enable=0 with 10 events -> no irq, pending_cnt=10; enable=1 -> irq next cycle, irq_cnt=10.
- CNT_W=4, count_thresh=0, enable=0, 20 events -> pending_cnt saturates at 15. Assert rst while irq=1 -> irq=0, pending_cnt=0, irq_cnt=0. Spurious irq_ack in IDLE -> no change.
